// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store unit between a core and a
// word-wide memory port. It aligns store data and byte enables onto the word bus,
// and extracts and extends load data from the returned word.
// Misaligned and illegal-size requests are answered with rsp_err and never
// reach memory.
// Optional build macro LSU_TIMEOUT_EN: when it is defined, WAIT gives up after
// TIMEOUT cycles without mem_ack and answers with rsp_err.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_v,
  output logic        req_rdy,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_v,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        mem_r_v,
  output logic        mem_w_v,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_data,
  output logic [3:0]  mem_strobe,
  input  logic [31:0] mem_resp,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state, state_nx;
  logic        we_q;
  logic [31:0] adr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] data_q;
  logic        err_q;
  logic        accept;
  logic        tmo_hit;

  // A request is legal when the size is defined and the address is naturally aligned.
  function automatic logic req_legal(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: req_legal = 1'b1;
      SZ_HALF: req_legal = (lo[0] == 1'b0);
      SZ_WORD: req_legal = (lo == 2'b00);
      default: req_legal = 1'b0;
    endcase
  endfunction

  // Picks the addressed lane out of the memory word and sign- or zero-extends it.
  function automatic logic [31:0] format_load(input logic [31:0] resp,
                                              input logic [1:0]  lo,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [31:0] lane;
    lane = resp >> {lo, 3'b000};
    case (size)
      SZ_BYTE: format_load = uns ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      SZ_HALF: format_load = uns ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: format_load = lane;
    endcase
  endfunction

  assign req_rdy = rst_n && (state == S_IDLE);
  assign accept  = req_v && req_rdy;

`ifdef LSU_TIMEOUT_EN
  localparam int          CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] tmo_cnt_q;

  // WAIT cycle counter; it restarts from zero every time WAIT is entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (state == S_WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  assign tmo_hit = (state == S_WAIT) && !mem_ack && (tmo_cnt_q == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  // State register plus the captured request and the pending response.
  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too so the outputs are clean 0 right after reset.
    if (!rst_n) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q    <= req_we;
        adr_q   <= req_adr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        data_q  <= '0;
        err_q   <= !req_legal(req_size, req_adr[1:0]);
      end else if (state == S_WAIT && mem_ack) begin
        data_q <= we_q ? 32'h0 : format_load(mem_resp, adr_q[1:0], size_q, uns_q);
        err_q  <= 1'b0;
      end else if (tmo_hit) begin
        data_q <= '0;
        err_q  <= 1'b1;
      end
    end
  end

  // Next-state decode; memory ack is only looked at while in WAIT.
  always_comb begin
    // NOTE: default first so no path leaves state_nx unassigned (no latch).
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = req_legal(req_size, req_adr[1:0]) ? S_REQ : S_RESP;
      S_REQ:  state_nx = S_WAIT;
      S_WAIT: if (mem_ack || tmo_hit) state_nx = S_RESP;
      S_RESP: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Memory-side request: driven only during the single REQ cycle, zero otherwise.
  always_comb begin
    mem_r_v    = 1'b0;
    mem_w_v    = 1'b0;
    mem_adr    = '0;
    mem_data   = '0;
    mem_strobe = '0;
    if (state == S_REQ) begin
      mem_r_v  = !we_q;
      mem_w_v  = we_q;
      mem_adr  = {adr_q[31:2], 2'b00};
      mem_data = wdata_q << {adr_q[1:0], 3'b000};
      if (we_q) begin
        case (size_q)
          SZ_BYTE: mem_strobe = 4'b0001 << adr_q[1:0];
          SZ_HALF: mem_strobe = 4'b0011 << adr_q[1:0];
          default: mem_strobe = 4'b1111;
        endcase
      end
    end
  end

  // Core-side response: one-cycle pulse in RESP, data and error gated by it.
  always_comb begin
    rsp_v    = (state == S_RESP);
    rsp_data = rsp_v ? data_q : 32'h0;
    rsp_err  = rsp_v && err_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a table of single transactions with
// hand-computed results, followed by reset, stray-ack and no-ack sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_v;
  logic        req_rdy;
  logic        req_we;
  logic [31:0] req_adr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_v;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        mem_r_v;
  logic        mem_w_v;
  logic [31:0] mem_adr;
  logic [31:0] mem_data;
  logic [3:0]  mem_strobe;
  logic [31:0] mem_resp;
  logic        mem_ack;

  int checks   = 0;
  int failures = 0;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_v(req_v), .req_rdy(req_rdy), .req_we(req_we), .req_adr(req_adr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_v(rsp_v), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_r_v(mem_r_v), .mem_w_v(mem_w_v), .mem_adr(mem_adr), .mem_data(mem_data),
    .mem_strobe(mem_strobe), .mem_resp(mem_resp), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] resp;
    logic        e_err;
    logic [31:0] e_data;
    logic [3:0]  e_strb;
    logic [31:0] e_madr;
    logic [31:0] e_mdata;
    int          e_lat;
    bit          no_ack;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one request and follows it to its response (bounded), acking in the first WAIT cycle.
  task automatic run_vec(input string tag, input vec_t v);
    int          lat = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    bit          pending = 0;
    bit          stray = 0;
    logic [3:0]  strb = '0;
    logic [31:0] madr = '0;
    logic [31:0] mdata = '0;
    logic [31:0] rdata = '0;
    logic        rerr = 1'b0;
    logic        rdy_at_rsp = 1'b0;
    for (int w = 0; w < 5; w++) begin
      @(negedge clk);
      if (req_rdy) break;
    end
    check({tag, "_rdy"}, 32'(req_rdy), 32'd1);
    req_v = 1'b1; req_we = v.we; req_adr = v.adr; req_wdata = v.wdata;
    req_size = v.size; req_unsigned = v.uns;
    @(posedge clk);
    #1 req_v = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_r_v || mem_w_v) begin
        n_rd += int'(mem_r_v);
        n_wr += int'(mem_w_v);
        strb = mem_strobe; madr = mem_adr; mdata = mem_data;
        pending = 1'b1;
      end else begin
        if (mem_strobe != 0 || mem_adr != 0 || mem_data != 0) stray = 1'b1;
        if (pending && !v.no_ack) begin
          mem_ack = 1'b1;
          mem_resp = v.resp;
          pending = 1'b0;
        end
      end
      if (rsp_v) begin
        lat = cyc; rdata = rsp_data; rerr = rsp_err; rdy_at_rsp = req_rdy;
        break;
      end
    end
    mem_ack = 1'b0;
    check({tag, "_lat"},   32'(lat), 32'(v.e_lat));
    check({tag, "_err"},   32'(rerr), 32'(v.e_err));
    check({tag, "_data"},  rdata, v.e_data);
    check({tag, "_nrd"},   32'(n_rd), (!v.e_err && !v.we) ? 32'd1 : 32'd0);
    check({tag, "_nwr"},   32'(n_wr), (!v.e_err && v.we) ? 32'd1 : 32'd0);
    check({tag, "_strb"},  32'(strb), 32'(v.e_strb));
    check({tag, "_madr"},  madr, v.e_madr);
    check({tag, "_mdata"}, mdata, v.e_mdata);
    check({tag, "_stray"}, 32'(stray), 32'd0);
    check({tag, "_rdyrsp"}, 32'(rdy_at_rsp), 32'd0);
  endtask

  initial begin
    int cnt;
    vec_t tv;
    //          we  adr           wdata          size   uns resp           err data           strb  madr          mdata          lat ack
    vecs[0]  = '{0, 32'h0000_2003, 32'h0,         2'b00, 0, 32'h80AB_CDEF, 0, 32'hFFFF_FF80, 4'h0, 32'h0000_2000, 32'h0,         3, 0};
    vecs[1]  = '{1, 32'h0000_2002, 32'h0000_1234, 2'b01, 0, 32'h0,         0, 32'h0,         4'hC, 32'h0000_2000, 32'h1234_0000, 3, 0};
    vecs[2]  = '{0, 32'h0000_2001, 32'h0,         2'b10, 0, 32'h0,         1, 32'h0,         4'h0, 32'h0,         32'h0,         1, 0};
    vecs[3]  = '{0, 32'h0000_2002, 32'h0,         2'b01, 1, 32'h9876_5432, 0, 32'h0000_9876, 4'h0, 32'h0000_2000, 32'h0,         3, 0};
    vecs[4]  = '{0, 32'h0000_2001, 32'h0,         2'b00, 1, 32'h9876_5432, 0, 32'h0000_0054, 4'h0, 32'h0000_2000, 32'h0,         3, 0};
    vecs[5]  = '{0, 32'h0000_2002, 32'h0,         2'b01, 0, 32'h9876_5432, 0, 32'hFFFF_9876, 4'h0, 32'h0000_2000, 32'h0,         3, 0};
    vecs[6]  = '{0, 32'h0000_2000, 32'h0,         2'b01, 0, 32'h9876_5432, 0, 32'h0000_5432, 4'h0, 32'h0000_2000, 32'h0,         3, 0};
    vecs[7]  = '{0, 32'h0000_2004, 32'h0,         2'b10, 1, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 4'h0, 32'h0000_2004, 32'h0,         3, 0};
    vecs[8]  = '{1, 32'h0000_2001, 32'h0000_00A5, 2'b00, 0, 32'h0,         0, 32'h0,         4'h2, 32'h0000_2000, 32'h0000_A500, 3, 0};
    vecs[9]  = '{1, 32'h0000_2008, 32'hCAFE_F00D, 2'b10, 0, 32'h0,         0, 32'h0,         4'hF, 32'h0000_2008, 32'hCAFE_F00D, 3, 0};
    vecs[10] = '{0, 32'h0000_2000, 32'h0,         2'b11, 0, 32'h0,         1, 32'h0,         4'h0, 32'h0,         32'h0,         1, 0};
    vecs[11] = '{1, 32'h0000_2003, 32'h0000_BEEF, 2'b01, 0, 32'h0,         1, 32'h0,         4'h0, 32'h0,         32'h0,         1, 0};
    vecs[12] = '{0, 32'h0000_2000, 32'h0,         2'b00, 0, 32'h1234_567F, 0, 32'h0000_007F, 4'h0, 32'h0000_2000, 32'h0,         3, 0};

    rst_n = 1'b0; req_v = 1'b0; req_we = 1'b0; req_adr = '0; req_wdata = '0;
    req_size = '0; req_unsigned = 1'b0; mem_resp = '0; mem_ack = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy",    32'(req_rdy), 32'd0);
    check("rst_rsp_v",  32'(rsp_v), 32'd0);
    check("rst_rsp",    {rsp_data[31:1], rsp_err}, 32'd0);
    check("rst_mem_v",  {30'd0, mem_r_v, mem_w_v}, 32'd0);
    check("rst_strb",   32'(mem_strobe), 32'd0);
    check("rst_madr",   mem_adr, 32'd0);
    check("rst_mdata",  mem_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_rdy", 32'(req_rdy), 32'd1);

    // Table of single transactions.
    for (int i = 0; i < 13; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Ack while idle must not produce a response.
    @(negedge clk);
    mem_ack = 1'b1; mem_resp = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      cnt += int'(rsp_v);
    end
    check("idle_ack_rsp", 32'(cnt), 32'd0);
    check("idle_ack_rdy", 32'(req_rdy), 32'd1);

    // Reset while in WAIT aborts the load; acks afterwards are ignored.
    @(negedge clk);
    req_v = 1'b1; req_we = 1'b0; req_adr = 32'h0000_2004; req_size = 2'b10; req_unsigned = 1'b0;
    @(posedge clk);
    #1 req_v = 1'b0;
    @(negedge clk);
    check("rw_req", 32'(mem_r_v), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_resp = 32'h1111_2222;
    @(negedge clk);
    mem_ack = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check("rw_rdy", 32'(req_rdy), 32'd1);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      cnt += int'(rsp_v);
    end
    check("rw_no_rsp", 32'(cnt), 32'd0);

    // No ack at all: either a timeout error or an indefinite wait.
`ifdef LSU_TIMEOUT_EN
    tv = '{0, 32'h0000_2010, 32'h0, 2'b10, 0, 32'h0, 1, 32'h0, 4'h0, 32'h0000_2010, 32'h0, 18, 1};
    run_vec("tmo", tv);
`else
    tv = vecs[0];
    @(negedge clk);
    req_v = 1'b1; req_we = 1'b0; req_adr = 32'h0000_2010; req_size = 2'b10;
    @(posedge clk);
    #1 req_v = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      cnt += int'(rsp_v);
    end
    check("noack_rsp", 32'(cnt), 32'd0);
    check("noack_rdy", 32'(req_rdy), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // The unit keeps working after the abort.
    run_vec("post", vecs[3]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
